// File: rtl/icache_refill_unit.sv
// Instruction-cache line refill engine.
// Takes a line-fill request from the icache miss port, issues block_size
// sequential word reads with a bounded number in flight, assembles the
// returned beats into one line and hands it back with a single-cycle pulse.
module icache_refill_unit #(
    parameter int data_width      = 32,
    parameter int address_width   = 32,
    parameter int block_size      = 8,
    parameter int max_outstanding = 4,
    localparam int offset_width   = $clog2(data_width * block_size / 8),
    localparam int word_idx_width = $clog2(block_size),
    localparam int line_width     = block_size * data_width
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    ADDR_TO_L2_VALID,
    input  logic [address_width-offset_width-1:0]   ADDR_TO_L2,
    output logic [line_width-1:0]                   DATA_FROM_L2,
    output logic                                    DATA_FROM_L2_VALID,
    output logic                                    MEM_RD_VALID,
    input  logic                                    MEM_RD_READY,
    output logic [address_width-1:0]                MEM_RD_ADDR,
    input  logic                                    MEM_DATA_VALID,
    input  logic [data_width-1:0]                   MEM_DATA,
    output logic                                    BUSY,
    output logic                                    REQ_DROPPED
);

    localparam int byte_off_width  = offset_width - word_idx_width;
    localparam int cnt_width       = word_idx_width + 1;
    localparam int line_addr_width = address_width - offset_width;

    localparam logic [cnt_width-1:0] block_cnt   = cnt_width'(block_size);
    localparam logic [cnt_width-1:0] max_out_cnt = cnt_width'(max_outstanding);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]                 state_q;
    logic [line_addr_width-1:0] line_q;
    logic [cnt_width-1:0]       issue_cnt;
    logic [cnt_width-1:0]       recv_cnt;
    logic [line_width-1:0]      line_buf;
    logic [line_width-1:0]      line_out;
    logic                       line_valid_q;
    logic                       rd_valid_q;
    logic [address_width-1:0]   rd_addr_q;
    logic                       req_dropped_q;

    logic                       rd_fire;
    logic                       beat;
    logic                       last_beat;
    logic                       issue_ok;
    logic [cnt_width-1:0]       issue_next;
    logic [cnt_width-1:0]       recv_next;
    logic [line_width-1:0]      line_merged;
    int                         word_base;

    // Next counter values, beat merge into the line and the issue-permission test.
    always_comb begin
        rd_fire     = rd_valid_q && MEM_RD_READY;
        beat        = (state_q == FETCH) && MEM_DATA_VALID;
        issue_next  = issue_cnt + cnt_width'(rd_fire);
        recv_next   = recv_cnt + cnt_width'(beat);
        last_beat   = beat && (recv_cnt == block_cnt - 1'b1);
        word_base   = int'(recv_cnt[word_idx_width-1:0]) * data_width;
        line_merged = line_buf;
        if (beat) begin
            line_merged[word_base +: data_width] = MEM_DATA;
        end
        // Registered VALID must reflect the counters as they will be after
        // this edge, so the limit test is made on the next-state values.
        issue_ok = (issue_next < block_cnt) && ((issue_next - recv_next) < max_out_cnt);
    end

    // Refill state machine, issue/receive counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            line_q        <= '0;
            issue_cnt     <= '0;
            recv_cnt      <= '0;
            line_buf      <= '0;
            line_out      <= '0;
            line_valid_q  <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_addr_q     <= '0;
            req_dropped_q <= 1'b0;
        end else begin
            line_valid_q  <= 1'b0;
            req_dropped_q <= ADDR_TO_L2_VALID && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (ADDR_TO_L2_VALID) begin
                        state_q    <= FETCH;
                        line_q     <= ADDR_TO_L2;
                        issue_cnt  <= '0;
                        recv_cnt   <= '0;
                        rd_valid_q <= 1'b1;
                        rd_addr_q  <= {ADDR_TO_L2, {word_idx_width{1'b0}}, {byte_off_width{1'b0}}};
                    end
                end
                FETCH: begin
                    issue_cnt <= issue_next;
                    recv_cnt  <= recv_next;
                    line_buf  <= line_merged;
                    // Address only moves after a handshake, so it is stable while stalled.
                    rd_addr_q <= {line_q, issue_next[word_idx_width-1:0], {byte_off_width{1'b0}}};
                    if (last_beat) begin
                        state_q      <= DONE;
                        line_out     <= line_merged;
                        line_valid_q <= 1'b1;
                        rd_valid_q   <= 1'b0;
                    end else begin
                        rd_valid_q <= issue_ok;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign DATA_FROM_L2       = line_out;
    assign DATA_FROM_L2_VALID = line_valid_q;
    assign MEM_RD_VALID       = rd_valid_q;
    assign MEM_RD_ADDR        = rd_addr_q;
    assign BUSY               = (state_q != IDLE);
    assign REQ_DROPPED        = req_dropped_q;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Bench for icache_refill_unit: two instances (max_outstanding 4 and 1), each
// with a behavioural memory and a line-level reference model.
module tb_icache_refill_unit;

    localparam int LAW = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;

    logic           req_v [2];
    logic [LAW-1:0] req_a [2];
    int             lat [2];
    int             rdy_mode [2];
    int             data_mode;
    logic           spur_dv;
    logic [31:0]    spur_data;

    int n_chk = 0;
    int n_fail = 0;

    int            hs_c[$];
    logic [31:0]   hs_a[$];
    int            beat_c[$];
    int            dv_c[$];
    int            drop_c[$];
    logic [255:0]  dv_line;

    always #5 clk = ~clk;

    always @(posedge clk) edge_n = edge_n + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (data_mode == 0) return 32'h11111111 * ({29'd0, a[4:2]} + 32'd1);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word(base + 32'(4 * i));
        return l;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int MAXO = (g == 0) ? 4 : 1;

        logic [255:0] dout;
        logic         dout_v, rd_v, busy, dropped, mem_dv;
        logic [31:0]  rd_a, mem_d;
        logic         rdy = 1'b1;
        logic         mdv = 1'b0;
        logic [31:0]  mdat = '0;

        int          due_q[$];
        logic [31:0] dq[$];
        bit          armed = 0, m_fetch = 0, m_done = 0;
        bit          exp_rv = 0, exp_dv = 0, exp_drop = 0, hs, beat;
        logic [31:0] m_base = '0;
        int          m_iss = 0, m_rcv = 0, tmp;
        logic [255:0] m_line = '0;

        assign mem_dv = mdv | ((g == 0) && spur_dv);
        assign mem_d  = ((g == 0) && spur_dv) ? spur_data : mdat;

        icache_refill_unit #(.max_outstanding(MAXO)) dut (
            .CLK                (clk),
            .RST                (rst),
            .ADDR_TO_L2_VALID   (req_v[g]),
            .ADDR_TO_L2         (req_a[g]),
            .DATA_FROM_L2       (dout),
            .DATA_FROM_L2_VALID (dout_v),
            .MEM_RD_VALID       (rd_v),
            .MEM_RD_READY       (rdy),
            .MEM_RD_ADDR        (rd_a),
            .MEM_DATA_VALID     (mem_dv),
            .MEM_DATA           (mem_d),
            .BUSY               (busy),
            .REQ_DROPPED        (dropped)
        );

        // Memory and reference model: account for what happened at this edge,
        // compare the outputs, then choose READY/data for the next edge.
        always @(posedge clk) begin
            #1;
            if (rst) begin
                armed = 1; m_fetch = 0; m_done = 0; m_iss = 0; m_rcv = 0;
                m_line = '0; exp_rv = 0; exp_dv = 0; exp_drop = 0;
                due_q.delete(); dq.delete();
            end else if (armed) begin
                exp_drop = req_v[g] && (m_fetch || m_done);
                exp_dv = 0;
                hs = exp_rv && rdy;
                beat = m_fetch && mem_dv;
                if (m_done) begin
                    m_done = 0;
                end else if (m_fetch) begin
                    if (hs) begin
                        due_q.push_back(edge_n + lat[g]);
                        dq.push_back(mem_word(m_base + 32'(4 * m_iss)));
                        m_iss++;
                    end
                    if (beat) begin
                        m_rcv++;
                        if (m_rcv == 8) begin
                            m_fetch = 0; m_done = 1; exp_dv = 1;
                            m_line = line_of(m_base);
                        end
                    end
                end else if (req_v[g]) begin
                    m_fetch = 1; m_base = {req_a[g], 5'b0}; m_iss = 0; m_rcv = 0;
                end
                exp_rv = m_fetch && (m_iss < 8) && ((m_iss - m_rcv) < MAXO);
            end
            if (armed) begin
                chk($sformatf("u%0d_rd_valid", g), rd_v, exp_rv);
                if (exp_rv) chk($sformatf("u%0d_rd_addr", g), rd_a, m_base + 32'(4 * m_iss));
                if (rst) chk($sformatf("u%0d_rd_addr_rst", g), rd_a, 0);
                chk($sformatf("u%0d_line_valid", g), dout_v, exp_dv);
                chk($sformatf("u%0d_dropped", g), dropped, exp_drop);
                chk($sformatf("u%0d_busy", g), busy, m_fetch || m_done);
                chk($sformatf("u%0d_line", g), dout, m_line);
            end
            case (rdy_mode[g])
                0:       rdy = 1'b1;
                1:       rdy = ~rdy;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (due_q.size() > 0 && due_q[0] <= edge_n + 1) begin
                tmp  = due_q.pop_front();
                mdat = dq.pop_front();
                mdv  = 1'b1;
            end else begin
                mdv  = 1'b0;
                mdat = $urandom;
            end
        end
    end

    task automatic sample(input int g, output logic v, output logic r, output logic dv,
                          output logic dn, output logic dp, output logic bz,
                          output logic [31:0] ad, output logic [255:0] ln);
        if (g == 0) begin
            v = u[0].rd_v; r = u[0].rdy; dv = u[0].mem_dv; dn = u[0].dout_v;
            dp = u[0].dropped; bz = u[0].busy; ad = u[0].rd_a; ln = u[0].dout;
        end else begin
            v = u[1].rd_v; r = u[1].rdy; dv = u[1].mem_dv; dn = u[1].dout_v;
            dp = u[1].dropped; bz = u[1].busy; ad = u[1].rd_a; ln = u[1].dout;
        end
    endtask

    // Issue one request and log events by cycle number relative to the request cycle.
    task automatic watch(input int g, input logic [LAW-1:0] a, input int budget,
                         input int rst_after, input int drop_at, input logic [LAW-1:0] drop_a);
        int e0, c, beats, post;
        bit rst_done;
        logic v, r, dv, dn, dp, bz;
        logic [31:0] ad;
        logic [255:0] ln;
        hs_c.delete(); hs_a.delete(); beat_c.delete(); dv_c.delete(); drop_c.delete();
        dv_line = '0;
        @(negedge clk);
        req_v[g] = 1'b1; req_a[g] = a; e0 = edge_n + 1;
        beats = 0; post = -1; rst_done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            req_v[g] = 1'b0; rst = 1'b0;
            c = edge_n + 1 - e0;
            sample(g, v, r, dv, dn, dp, bz, ad, ln);
            if (v && r) begin hs_c.push_back(c); hs_a.push_back(ad); end
            if (dn) begin dv_c.push_back(c); dv_line = ln; end
            if (dp) drop_c.push_back(c);
            if (rst_after > 0 && !rst_done && beats == rst_after) begin
                rst = 1'b1; rst_done = 1; post = 3;
            end
            if (dv) begin beat_c.push_back(c); beats++; end
            if (c == drop_at) begin req_v[g] = 1'b1; req_a[g] = drop_a; end
            if (dn && post < 0) post = 2;
            if (post == 0) break;
            if (post > 0) post--;
        end
    endtask

    logic v_s, r_s, dv_s, dn_s, dp_s, bz_s;
    logic [31:0]  ad_s;
    logic [255:0] ln_s, save_l;
    int drop_at_r;
    logic [LAW-1:0] ra;

    initial begin
        req_v[0] = 0; req_v[1] = 0; req_a[0] = '0; req_a[1] = '0;
        spur_dv = 0; spur_data = '0; data_mode = 0;
        lat[0] = 1; lat[1] = 1; rdy_mode[0] = 0; rdy_mode[1] = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        sample(0, v_s, r_s, dv_s, dn_s, dp_s, bz_s, ad_s, ln_s);
        chk("reset_rd_valid", v_s, 0);
        chk("reset_rd_addr", ad_s, 0);
        chk("reset_line_valid", dn_s, 0);
        chk("reset_busy", bz_s, 0);
        chk("reset_dropped", dp_s, 0);
        chk("reset_line", ln_s, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait memory, line 0x10.
        watch(0, 27'h10, 60, 0, -1, '0);
        chk("zw_hs_count", hs_c.size(), 8);
        foreach (hs_c[k]) begin
            chk("zw_hs_cycle", hs_c[k], k + 1);
            chk("zw_hs_addr", hs_a[k], 32'h200 + 32'(4 * k));
        end
        chk("zw_beat_count", beat_c.size(), 8);
        foreach (beat_c[k]) chk("zw_beat_cycle", beat_c[k], k + 2);
        chk("zw_valid_count", dv_c.size(), 1);
        if (dv_c.size() > 0) chk("zw_valid_cycle", dv_c[0], 10);
        chk("zw_word7", dv_line[255:224], 32'h88888888);
        chk("zw_line", dv_line, line_of(32'h200));

        // One outstanding read, latency 3.
        lat[1] = 3; rdy_mode[1] = 0;
        watch(1, 27'h10, 200, 0, -1, '0);
        chk("mo1_hs_count", hs_c.size(), 8);
        chk("mo1_valid_count", dv_c.size(), 1);
        chk("mo1_line", dv_line, line_of(32'h200));
        for (int k = 1; k < 8; k++)
            if (k < hs_c.size() && k - 1 < beat_c.size())
                chk("mo1_hs_after_beat", hs_c[k] > beat_c[k-1], 1);

        // READY toggling, latency 5.
        data_mode = 1; lat[0] = 5; rdy_mode[0] = 1;
        watch(0, 27'h1234, 200, 0, -1, '0);
        chk("tog_hs_count", hs_c.size(), 8);
        chk("tog_valid_count", dv_c.size(), 1);
        chk("tog_line", dv_line, line_of({27'h1234, 5'b0}));

        // Second request while busy is dropped.
        data_mode = 0; lat[0] = 1; rdy_mode[0] = 0;
        watch(0, 27'h2, 60, 0, 4, 27'h3);
        chk("drop_count", drop_c.size(), 1);
        if (drop_c.size() > 0) chk("drop_cycle", drop_c[0], 5);
        chk("drop_hs_count", hs_c.size(), 8);
        foreach (hs_a[k]) chk("drop_hs_addr", hs_a[k], 32'h40 + 32'(4 * k));
        chk("drop_valid_count", dv_c.size(), 1);

        // Reset after three beats, then a fresh refill of line 0x7.
        data_mode = 1; lat[0] = 2; rdy_mode[0] = 2;
        watch(0, 27'h5, 200, 3, -1, '0);
        chk("abort_valid_count", dv_c.size(), 0);
        sample(0, v_s, r_s, dv_s, dn_s, dp_s, bz_s, ad_s, ln_s);
        chk("abort_busy", bz_s, 0);
        chk("abort_line", ln_s, 0);
        watch(0, 27'h7, 200, 0, -1, '0);
        chk("fresh_hs_count", hs_c.size(), 8);
        if (hs_a.size() == 8) begin
            chk("fresh_first_addr", hs_a[0], 32'hE0);
            chk("fresh_last_addr", hs_a[7], 32'hFC);
        end
        chk("fresh_valid_count", dv_c.size(), 1);
        chk("fresh_line", dv_line, line_of(32'hE0));

        // Spurious beat while idle.
        data_mode = 0;
        sample(0, v_s, r_s, dv_s, dn_s, dp_s, bz_s, ad_s, save_l);
        @(negedge clk); spur_dv = 1'b1; spur_data = 32'hDEADBEEF;
        @(negedge clk); spur_dv = 1'b0;
        @(negedge clk);
        sample(0, v_s, r_s, dv_s, dn_s, dp_s, bz_s, ad_s, ln_s);
        chk("spur_line_held", ln_s, save_l);
        chk("spur_busy", bz_s, 0);
        watch(0, 27'h9, 60, 0, -1, '0);
        chk("spur_next_word0", dv_line[31:0], mem_word({27'h9, 5'b0}));
        chk("spur_next_line", dv_line, line_of({27'h9, 5'b0}));

        // Randomised refills.
        data_mode = 1;
        for (int t = 0; t < 10; t++) begin
            rdy_mode[0] = $urandom_range(0, 2);
            lat[0] = $urandom_range(1, 6);
            ra = LAW'($urandom);
            drop_at_r = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9) : -1;
            watch(0, ra, 300, 0, drop_at_r, LAW'($urandom));
            chk("rnd_hs_count", hs_c.size(), 8);
            chk("rnd_valid_count", dv_c.size(), 1);
            chk("rnd_drop_count", drop_c.size(), (drop_at_r > 0) ? 1 : 0);
            chk("rnd_line", dv_line, line_of({ra, 5'b0}));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
